// File: rtl/level_sequencer_if.sv
// Bundles the level sequencer's control inputs, VGA/memory addressing and
// init-sweep outputs; the controller drives from master, the sequencer from slave.
interface level_sequencer_if #(
  parameter int NUM_LEVELS = 8,
  parameter int ADDR_W     = 11,
  parameter int PIX_ADDR_W = 12,
  parameter int BCD_DIGITS = 2
);
  localparam int LVL_W = $clog2(NUM_LEVELS);

  logic                    new_level;
  logic                    restart;
  logic                    jump_en;
  logic [LVL_W-1:0]        jump_level;
  logic                    initialize_level;
  logic [PIX_ADDR_W-1:0]   vga_addr;
  logic [ADDR_W-1:0]       mem_addr;
  logic [LVL_W-1:0]        level_idx;
  logic [ADDR_W-1:0]       level_base;
  logic [4*BCD_DIGITS-1:0] hex_out;
  logic                    init_busy;
  logic                    init_valid;
  logic [ADDR_W-1:0]       init_addr;
  logic                    init_done;
  logic                    game_done;

  modport master (
    output new_level, restart, jump_en, jump_level, initialize_level, vga_addr,
    input  mem_addr, level_idx, level_base, hex_out, init_busy, init_valid,
           init_addr, init_done, game_done
  );

  modport slave (
    input  new_level, restart, jump_en, jump_level, initialize_level, vga_addr,
    output mem_addr, level_idx, level_base, hex_out, init_busy, init_valid,
           init_addr, init_done, game_done
  );
endinterface

// File: rtl/level_sequencer.sv
// Level controller: tracks the current level, its memory base and BCD number,
// offsets VGA tile addresses, and sweeps a level's words for the RAM copy.
module level_sequencer #(
  parameter int NUM_LEVELS  = 8,
  parameter int LEVEL_WORDS = 75,
  parameter int ADDR_W      = 11,
  parameter int PIX_ADDR_W  = 12,
  parameter int BCD_DIGITS  = 2,
  parameter bit WRAP_MODE   = 1'b1
) (
  input logic Clk,
  input logic RESET,
  level_sequencer_if.slave bus
);
  localparam int LVL_W = $clog2(NUM_LEVELS);
  localparam int CNT_W = (LEVEL_WORDS > 1) ? $clog2(LEVEL_WORDS) : 1;
  localparam int SUM_W = (ADDR_W > PIX_ADDR_W) ? ADDR_W : PIX_ADDR_W;
  localparam int HEX_W = 4 * BCD_DIGITS;
  localparam logic [HEX_W-1:0] BCD_ONE = HEX_W'(1);

  if (NUM_LEVELS < 2) begin : g_bad_levels
    $error("level_sequencer: NUM_LEVELS must be at least 2");
  end
  if (LEVEL_WORDS < 1) begin : g_bad_words
    $error("level_sequencer: LEVEL_WORDS must be at least 1");
  end
  if (longint'(NUM_LEVELS) * LEVEL_WORDS > (longint'(1) << ADDR_W)) begin : g_bad_addr
    $error("level_sequencer: levels do not fit in ADDR_W");
  end
  if (NUM_LEVELS > 10 ** BCD_DIGITS - 1) begin : g_bad_bcd
    $error("level_sequencer: BCD_DIGITS too small for NUM_LEVELS");
  end

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_e;

  function automatic logic [HEX_W-1:0] toBcd(input int value);
    logic [HEX_W-1:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [HEX_W-1:0] bcdInc(input logic [HEX_W-1:0] d);
    logic [HEX_W-1:0] r;
    logic carry;
    r = d;
    carry = 1'b1;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LVL_W-1:0]  levelIdx_q, levelIdx_d;
  logic [ADDR_W-1:0] levelBase_q, levelBase_d;
  logic [HEX_W-1:0]  bcd_q, bcd_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic              gameDone_q, gameDone_d;
  logic              newLevel_q, initLevel_q;
  logic              newLevelEvt, initEvt;
  logic [SUM_W-1:0]  pixSum;

  assign newLevelEvt = bus.new_level & ~newLevel_q;
  assign initEvt     = bus.initialize_level & ~initLevel_q;
  assign pixSum      = SUM_W'(levelBase_q) + SUM_W'(bus.vga_addr);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    levelIdx_d  = levelIdx_q;
    levelBase_d = levelBase_q;
    bcd_d       = bcd_q;
    memAddr_d   = pixSum[ADDR_W-1:0];
    // Wrap mode reports completion as a pulse; hold mode keeps it until cleared.
    gameDone_d  = WRAP_MODE ? 1'b0 : gameDone_q;

    if (bus.restart) begin
      levelIdx_d  = '0;
      levelBase_d = '0;
      bcd_d       = BCD_ONE;
      gameDone_d  = 1'b0;
    end else if (state_q == IDLE) begin
      if (bus.jump_en) begin
        if (int'(bus.jump_level) < NUM_LEVELS) begin
          levelIdx_d  = bus.jump_level;
          levelBase_d = ADDR_W'(int'(bus.jump_level) * LEVEL_WORDS);
          bcd_d       = toBcd(int'(bus.jump_level) + 1);
          gameDone_d  = 1'b0;
        end
      end else if (newLevelEvt) begin
        if (int'(levelIdx_q) < NUM_LEVELS - 1) begin
          levelIdx_d  = levelIdx_q + 1'b1;
          levelBase_d = levelBase_q + ADDR_W'(LEVEL_WORDS);
          bcd_d       = bcdInc(bcd_q);
        end else begin
          gameDone_d = 1'b1;
          if (WRAP_MODE) begin
            levelIdx_d  = '0;
            levelBase_d = '0;
            bcd_d       = BCD_ONE;
          end
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (initEvt) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(LEVEL_WORDS - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.restart) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      levelIdx_q  <= '0;
      levelBase_q <= '0;
      bcd_q       <= BCD_ONE;
      memAddr_q   <= '0;
      gameDone_q  <= 1'b0;
      newLevel_q  <= 1'b0;
      initLevel_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      levelIdx_q  <= levelIdx_d;
      levelBase_q <= levelBase_d;
      bcd_q       <= bcd_d;
      memAddr_q   <= memAddr_d;
      gameDone_q  <= gameDone_d;
      newLevel_q  <= bus.new_level;
      initLevel_q <= bus.initialize_level;
    end
  end

  assign bus.mem_addr   = memAddr_q;
  assign bus.level_idx  = levelIdx_q;
  assign bus.level_base = levelBase_q;
  assign bus.hex_out    = bcd_q;
  assign bus.init_busy  = (state_q != IDLE);
  assign bus.init_valid = (state_q == SWEEP);
  assign bus.init_addr  = levelBase_q + ADDR_W'(cnt_q);
  assign bus.init_done  = (state_q == DONE);
  assign bus.game_done  = gameDone_q;
endmodule

// File: tb/tb_level_sequencer.sv
// Self-checking bench: dutA is 8 levels with wrap, dutB is 12 levels with hold;
// memory and sweep addresses go through expectation queues.
module tb_level_sequencer;
  logic Clk;
  logic RESET;
  int assertCount = 0;
  int failCount = 0;
  logic [10:0] memQ[$];
  logic [10:0] initQ[$];

  level_sequencer_if #(.NUM_LEVELS(8),  .ADDR_W(11), .PIX_ADDR_W(12), .BCD_DIGITS(2)) busA ();
  level_sequencer_if #(.NUM_LEVELS(12), .ADDR_W(11), .PIX_ADDR_W(12), .BCD_DIGITS(2)) busB ();

  level_sequencer #(.NUM_LEVELS(8), .LEVEL_WORDS(75), .ADDR_W(11), .PIX_ADDR_W(12),
                    .BCD_DIGITS(2), .WRAP_MODE(1'b1))
    dutA (.Clk(Clk), .RESET(RESET), .bus(busA));

  level_sequencer #(.NUM_LEVELS(12), .LEVEL_WORDS(75), .ADDR_W(11), .PIX_ADDR_W(12),
                    .BCD_DIGITS(2), .WRAP_MODE(1'b0))
    dutB (.Clk(Clk), .RESET(RESET), .bus(busB));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  // Decimal digits of the 1-based level number, computed directly from the index.
  function automatic logic [7:0] expHex(input int idx);
    int n;
    n = idx + 1;
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic clearInputs();
    busA.new_level = 0; busA.restart = 0; busA.jump_en = 0; busA.jump_level = '0;
    busA.initialize_level = 0; busA.vga_addr = '0;
    busB.new_level = 0; busB.restart = 0; busB.jump_en = 0; busB.jump_level = '0;
    busB.initialize_level = 0; busB.vga_addr = '0;
  endtask

  task automatic test_reset();
    clearInputs();
    RESET = 1'b1;
    cycle();
    cycle();
    assertCount++; if (busA.level_idx !== 3'd0) begin failCount++; $display("[TB] FAIL reset_idx: got %0d expected 0", busA.level_idx); end
    assertCount++; if (busA.level_base !== 11'd0) begin failCount++; $display("[TB] FAIL reset_base: got %0d expected 0", busA.level_base); end
    assertCount++; if (busA.hex_out !== 8'h01) begin failCount++; $display("[TB] FAIL reset_hex: got %0h expected 01", busA.hex_out); end
    assertCount++; if (busA.mem_addr !== 11'd0) begin failCount++; $display("[TB] FAIL reset_mem: got %0d expected 0", busA.mem_addr); end
    assertCount++; if ({busA.init_busy, busA.init_valid, busA.init_done, busA.game_done} !== 4'b0000) begin
      failCount++; $display("[TB] FAIL reset_flags: got %b expected 0000", {busA.init_busy, busA.init_valid, busA.init_done, busA.game_done}); end
    assertCount++; if (busB.hex_out !== 8'h01) begin failCount++; $display("[TB] FAIL reset_hex_b: got %0h expected 01", busB.hex_out); end
    RESET = 1'b0;
    cycle();
  endtask

  task automatic test_mem_addr();
    int vgaVals[4];
    logic [10:0] exp;
    vgaVals = '{5, 10, 100, 4095};
    foreach (vgaVals[i]) begin
      busA.vga_addr = 12'(vgaVals[i]);
      memQ.push_back(11'(vgaVals[i]));
      cycle();
      exp = memQ.pop_front();
      assertCount++; if (busA.mem_addr !== exp) begin failCount++; $display("[TB] FAIL mem_addr_%0d: got %0d expected %0d", i, busA.mem_addr, exp); end
    end
  endtask

  task automatic test_advance_held();
    logic [10:0] exp;
    busA.vga_addr = 12'd10;
    memQ.push_back(11'd10);
    busA.new_level = 1'b1;
    cycle();
    exp = memQ.pop_front();
    assertCount++; if (busA.mem_addr !== exp) begin failCount++; $display("[TB] FAIL mem_old_base: got %0d expected %0d", busA.mem_addr, exp); end
    assertCount++; if (busA.level_idx !== 3'd1) begin failCount++; $display("[TB] FAIL adv_idx_first: got %0d expected 1", busA.level_idx); end
    cycle();
    cycle();
    busA.new_level = 1'b0;
    memQ.push_back(11'd85);
    cycle();
    exp = memQ.pop_front();
    assertCount++; if (busA.level_idx !== 3'd1) begin failCount++; $display("[TB] FAIL adv_idx_held: got %0d expected 1", busA.level_idx); end
    assertCount++; if (busA.level_base !== 11'd75) begin failCount++; $display("[TB] FAIL adv_base: got %0d expected 75", busA.level_base); end
    assertCount++; if (busA.hex_out !== 8'h02) begin failCount++; $display("[TB] FAIL adv_hex: got %0h expected 02", busA.hex_out); end
    assertCount++; if (busA.mem_addr !== exp) begin failCount++; $display("[TB] FAIL mem_new_base: got %0d expected %0d", busA.mem_addr, exp); end
  endtask

  task automatic test_wrap();
    int modelIdx;
    bit expWrap;
    modelIdx = 1;
    for (int k = 0; k < 7; k++) begin
      busA.new_level = 1'b1;
      cycle();
      expWrap = (modelIdx == 7);
      modelIdx = expWrap ? 0 : modelIdx + 1;
      assertCount++; if (busA.level_idx !== 3'(modelIdx)) begin failCount++; $display("[TB] FAIL wrap_idx_%0d: got %0d expected %0d", k, busA.level_idx, modelIdx); end
      assertCount++; if (busA.hex_out !== expHex(modelIdx)) begin failCount++; $display("[TB] FAIL wrap_hex_%0d: got %0h expected %0h", k, busA.hex_out, expHex(modelIdx)); end
      assertCount++; if (busA.level_base !== 11'(modelIdx * 75)) begin failCount++; $display("[TB] FAIL wrap_base_%0d: got %0d expected %0d", k, busA.level_base, modelIdx * 75); end
      assertCount++; if (busA.game_done !== expWrap) begin failCount++; $display("[TB] FAIL wrap_gd_%0d: got %0b expected %0b", k, busA.game_done, expWrap); end
      busA.new_level = 1'b0;
      cycle();
      assertCount++; if (busA.game_done !== 1'b0) begin failCount++; $display("[TB] FAIL wrap_gd_pulse_%0d: got %0b expected 0", k, busA.game_done); end
    end
  endtask

  task automatic test_hold_and_carry();
    int modelIdx;
    bit sticky;
    logic [10:0] exp;
    modelIdx = 0;
    sticky = 0;
    for (int k = 0; k < 12; k++) begin
      busB.new_level = 1'b1;
      cycle();
      if (modelIdx < 11) modelIdx++;
      else sticky = 1;
      assertCount++; if (busB.level_idx !== 4'(modelIdx)) begin failCount++; $display("[TB] FAIL hold_idx_%0d: got %0d expected %0d", k, busB.level_idx, modelIdx); end
      assertCount++; if (busB.hex_out !== expHex(modelIdx)) begin failCount++; $display("[TB] FAIL hold_hex_%0d: got %0h expected %0h", k, busB.hex_out, expHex(modelIdx)); end
      assertCount++; if (busB.game_done !== sticky) begin failCount++; $display("[TB] FAIL hold_gd_%0d: got %0b expected %0b", k, busB.game_done, sticky); end
      busB.new_level = 1'b0;
      cycle();
    end
    busB.vga_addr = 12'd4000;
    memQ.push_back(11'((825 + 4000) % 2048));
    repeat (3) begin
      cycle();
      assertCount++; if (busB.game_done !== 1'b1) begin failCount++; $display("[TB] FAIL hold_gd_sticky: got %0b expected 1", busB.game_done); end
    end
    exp = memQ.pop_front();
    assertCount++; if (busB.mem_addr !== exp) begin failCount++; $display("[TB] FAIL mem_trunc: got %0d expected %0d", busB.mem_addr, exp); end
    busB.vga_addr = '0;
  endtask

  task automatic test_jump();
    busB.jump_level = 4'd9;
    busB.jump_en = 1'b1;
    cycle();
    busB.jump_en = 1'b0;
    assertCount++; if (busB.level_idx !== 4'd9) begin failCount++; $display("[TB] FAIL jump_idx: got %0d expected 9", busB.level_idx); end
    assertCount++; if (busB.level_base !== 11'd675) begin failCount++; $display("[TB] FAIL jump_base: got %0d expected 675", busB.level_base); end
    assertCount++; if (busB.hex_out !== 8'h10) begin failCount++; $display("[TB] FAIL jump_hex: got %0h expected 10", busB.hex_out); end
    assertCount++; if (busB.game_done !== 1'b0) begin failCount++; $display("[TB] FAIL jump_gd_clear: got %0b expected 0", busB.game_done); end
    busB.jump_level = 4'd13;
    busB.jump_en = 1'b1;
    cycle();
    busB.jump_en = 1'b0;
    assertCount++; if ({busB.level_idx, busB.level_base} !== {4'd9, 11'd675}) begin
      failCount++; $display("[TB] FAIL jump_oob: got idx %0d base %0d expected 9/675", busB.level_idx, busB.level_base); end
    busB.restart = 1'b1;
    cycle();
    busB.restart = 1'b0;
    assertCount++; if ({busB.level_idx, busB.hex_out} !== {4'd0, 8'h01}) begin
      failCount++; $display("[TB] FAIL restart_b: got idx %0d hex %0h expected 0/01", busB.level_idx, busB.hex_out); end
    busA.jump_level = 3'd2;
    busA.jump_en = 1'b1;
    cycle();
    busA.jump_en = 1'b0;
    assertCount++; if ({busA.level_idx, busA.level_base, busA.hex_out} !== {3'd2, 11'd150, 8'h03}) begin
      failCount++; $display("[TB] FAIL jump_a: got idx %0d base %0d hex %0h expected 2/150/03", busA.level_idx, busA.level_base, busA.hex_out); end
  endtask

  task automatic test_sweep();
    int validCnt;
    int doneCnt;
    bit finished;
    logic [10:0] exp;
    validCnt = 0;
    doneCnt = 0;
    finished = 0;
    initQ.delete();
    for (int a = 150; a < 225; a++) initQ.push_back(11'(a));
    busA.initialize_level = 1'b1;
    busA.jump_level = 3'd5;
    for (int c = 0; c < 200 && !finished; c++) begin
      cycle();
      if (busA.init_valid) begin
        validCnt++;
        assertCount++;
        if (initQ.size() == 0) begin failCount++; $display("[TB] FAIL sweep_extra: got addr %0d expected none", busA.init_addr); end
        else begin
          exp = initQ.pop_front();
          if (busA.init_addr !== exp) begin failCount++; $display("[TB] FAIL sweep_addr: got %0d expected %0d", busA.init_addr, exp); end
        end
      end
      if (busA.init_done) begin
        doneCnt++;
        assertCount++; if (initQ.size() != 0) begin failCount++; $display("[TB] FAIL sweep_done_early: got %0d left expected 0", initQ.size()); end
      end
      if (doneCnt > 0 && !busA.init_busy) finished = 1;
      busA.new_level = (c == 30);
      busA.jump_en = (c == 40);
    end
    busA.new_level = 1'b0;
    busA.jump_en = 1'b0;
    assertCount++; if (finished !== 1'b1) begin failCount++; $display("[TB] FAIL sweep_timeout: got busy %0b expected idle", busA.init_busy); end
    assertCount++; if (validCnt != 75) begin failCount++; $display("[TB] FAIL sweep_count: got %0d expected 75", validCnt); end
    assertCount++; if (doneCnt != 1) begin failCount++; $display("[TB] FAIL sweep_done_cnt: got %0d expected 1", doneCnt); end
    assertCount++; if ({busA.level_idx, busA.hex_out} !== {3'd2, 8'h03}) begin
      failCount++; $display("[TB] FAIL sweep_ignore: got idx %0d hex %0h expected 2/03", busA.level_idx, busA.hex_out); end
    cycle();
    assertCount++; if (busA.init_busy !== 1'b0) begin failCount++; $display("[TB] FAIL sweep_held_init: got busy %0b expected 0", busA.init_busy); end
    busA.initialize_level = 1'b0;
    cycle();
  endtask

  task automatic test_restart_mid_sweep();
    int doneCnt;
    doneCnt = 0;
    busA.initialize_level = 1'b1;
    cycle();
    assertCount++; if (busA.init_busy !== 1'b1) begin failCount++; $display("[TB] FAIL rst_sweep_start: got busy %0b expected 1", busA.init_busy); end
    repeat (19) cycle();
    busA.restart = 1'b1;
    cycle();
    busA.restart = 1'b0;
    assertCount++; if ({busA.init_busy, busA.init_valid, busA.init_done} !== 3'b000) begin
      failCount++; $display("[TB] FAIL restart_idle: got %b expected 000", {busA.init_busy, busA.init_valid, busA.init_done}); end
    assertCount++; if ({busA.level_idx, busA.level_base, busA.hex_out} !== {3'd0, 11'd0, 8'h01}) begin
      failCount++; $display("[TB] FAIL restart_level: got idx %0d base %0d hex %0h expected 0/0/01", busA.level_idx, busA.level_base, busA.hex_out); end
    for (int c = 0; c < 100; c++) begin
      cycle();
      if (busA.init_done) doneCnt++;
    end
    assertCount++; if (doneCnt != 0) begin failCount++; $display("[TB] FAIL restart_no_done: got %0d expected 0", doneCnt); end
    busA.initialize_level = 1'b0;
    cycle();
  endtask

  task automatic test_reset_mid_sweep();
    int doneCnt;
    doneCnt = 0;
    busA.jump_level = 3'd3;
    busA.jump_en = 1'b1;
    cycle();
    busA.jump_en = 1'b0;
    busA.vga_addr = 12'd7;
    busA.initialize_level = 1'b1;
    cycle();
    repeat (10) cycle();
    #2;
    RESET = 1'b1;
    #1;
    assertCount++; if ({busA.level_idx, busA.level_base, busA.hex_out, busA.mem_addr} !== {3'd0, 11'd0, 8'h01, 11'd0}) begin
      failCount++; $display("[TB] FAIL async_reset_level: got idx %0d base %0d hex %0h mem %0d expected 0/0/01/0", busA.level_idx, busA.level_base, busA.hex_out, busA.mem_addr); end
    assertCount++; if ({busA.init_busy, busA.init_valid, busA.init_done, busA.init_addr} !== {3'b000, 11'd0}) begin
      failCount++; $display("[TB] FAIL async_reset_init: got busy %0b valid %0b addr %0d expected 0/0/0", busA.init_busy, busA.init_valid, busA.init_addr); end
    busA.initialize_level = 1'b0;
    busA.vga_addr = '0;
    cycle();
    RESET = 1'b0;
    for (int c = 0; c < 80; c++) begin
      cycle();
      if (busA.init_done) doneCnt++;
    end
    assertCount++; if (doneCnt != 0) begin failCount++; $display("[TB] FAIL reset_no_done: got %0d expected 0", doneCnt); end
  endtask

  task automatic test_back_to_back();
    int validCnt;
    bit doneSeen;
    validCnt = 0;
    doneSeen = 0;
    busA.new_level = 1'b1;
    busA.initialize_level = 1'b1;
    cycle();
    busA.new_level = 1'b0;
    busA.initialize_level = 1'b0;
    assertCount++; if ({busA.level_idx, busA.init_valid, busA.init_addr} !== {3'd1, 1'b1, 11'd75}) begin
      failCount++; $display("[TB] FAIL b2b_first: got idx %0d valid %0b addr %0d expected 1/1/75", busA.level_idx, busA.init_valid, busA.init_addr); end
    for (int c = 0; c < 100 && !doneSeen; c++) begin
      if (busA.init_valid) validCnt++;
      if (busA.init_done) doneSeen = 1;
      cycle();
    end
    assertCount++; if (!doneSeen || validCnt != 75) begin
      failCount++; $display("[TB] FAIL b2b_sweep: got done %0b valid %0d expected 1/75", doneSeen, validCnt); end
    assertCount++; if (memQ.size() != 0) begin failCount++; $display("[TB] FAIL mem_queue: got %0d pending expected 0", memQ.size()); end
  endtask

  initial begin
    $display("[TB] level_sequencer bench starting");
    test_reset();
    test_mem_addr();
    test_advance_held();
    test_wrap();
    test_hold_and_carry();
    test_jump();
    test_sweep();
    test_restart_mid_sweep();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
